// File: rtl/heartbeat_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : heartbeat_pulse_gen
//  Description : Turns the 2-bit heartbeat code into a "lub-dub" double-pulse
//                LED waveform. The beat period is selected by the code that
//                was latched at the start of the beat. Time advances only on
//                the external prescaled tick strobe.
//  Ports       : clk          - system clock
//                rst_n        - asynchronous active-low reset
//                enable       - block enable; low returns to IDLE (synchronous)
//                tick         - time-base strobe, one clk wide per tick
//                heartbeat    - code: 0 fast, 1 normal, 2 slow, 3 sleep
//                led          - heartbeat LED (registered)
//                beat_pulse   - one-clk strobe at each beat start (registered)
//                beat_count   - beats since reset/enable, wraps 255->0
//                period_code  - code latched for the beat in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module heartbeat_pulse_gen #(
    parameter int ON_TICKS  = 2,
    parameter int GAP_TICKS = 2,
    parameter int PERIOD_0  = 10,
    parameter int PERIOD_1  = 16,
    parameter int PERIOD_2  = 24,
    parameter int PERIOD_3  = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       tick,
    input  logic [1:0] heartbeat,
    output logic       led,
    output logic       beat_pulse,
    output logic [7:0] beat_count,
    output logic [1:0] period_code
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LUB  = 3'd1,
        ST_GAP  = 3'd2,
        ST_DUB  = 3'd3,
        ST_REST = 3'd4
    } state_t;

    // Segment lengths in ticks. The REST length absorbs whatever is left of
    // the period after the two lobes and the gap.
    localparam logic [7:0] c_on_len  = 8'(ON_TICKS);
    localparam logic [7:0] c_gap_len = 8'(GAP_TICKS);
    localparam logic [7:0] c_rest_0  = 8'(PERIOD_0 - 2*ON_TICKS - GAP_TICKS);
    localparam logic [7:0] c_rest_1  = 8'(PERIOD_1 - 2*ON_TICKS - GAP_TICKS);
    localparam logic [7:0] c_rest_2  = 8'(PERIOD_2 - 2*ON_TICKS - GAP_TICKS);
    localparam logic [7:0] c_rest_3  = 8'(PERIOD_3 - 2*ON_TICKS - GAP_TICKS);

    state_t     state_q,       state_d;
    logic [7:0] cnt_q,         cnt_d;
    logic       led_q,         led_d;
    logic       beat_pulse_q,  beat_pulse_d;
    logic [7:0] beat_count_q,  beat_count_d;
    logic [1:0] period_code_q, period_code_d;

    logic [7:0] w_rest_len;
    logic [7:0] w_len;
    logic       w_last;
    logic       w_start_beat;

    // REST length follows the latched code, so a mid-beat code change cannot
    // stretch or truncate the beat in progress.
    always_comb begin
        w_rest_len = c_rest_3;
        case (period_code_q)
            2'd0:    w_rest_len = c_rest_0;
            2'd1:    w_rest_len = c_rest_1;
            2'd2:    w_rest_len = c_rest_2;
            default: w_rest_len = c_rest_3;
        endcase
    end

    always_comb begin
        w_len = 8'd1;
        case (state_q)
            ST_LUB:  w_len = c_on_len;
            ST_GAP:  w_len = c_gap_len;
            ST_DUB:  w_len = c_on_len;
            ST_REST: w_len = w_rest_len;
            default: w_len = 8'd1;
        endcase
    end

    assign w_last = (cnt_q == (w_len - 8'd1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        beat_count_d  = beat_count_q;
        period_code_d = period_code_q;
        beat_pulse_d  = 1'b0;
        w_start_beat  = 1'b0;

        if (!enable) begin
            // Disable wins over tick; the latched code is kept.
            state_d      = ST_IDLE;
            cnt_d        = 8'd0;
            beat_count_d = 8'd0;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: w_start_beat = 1'b1;
                ST_LUB: begin
                    if (w_last) begin
                        state_d = ST_GAP;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (w_last) begin
                        state_d = ST_DUB;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_DUB: begin
                    if (w_last) begin
                        state_d = ST_REST;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_REST: begin
                    if (w_last) begin
                        w_start_beat = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end

        // Every entry into LUB is a beat start: sample the code, bump the
        // count and fire the strobe on the same edge as the LED rise.
        if (w_start_beat) begin
            state_d       = ST_LUB;
            cnt_d         = 8'd0;
            period_code_d = heartbeat;
            beat_count_d  = beat_count_q + 8'd1;
            beat_pulse_d  = 1'b1;
        end

        led_d = (state_d == ST_LUB) || (state_d == ST_DUB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            led_q         <= 1'b0;
            beat_pulse_q  <= 1'b0;
            beat_count_q  <= 8'd0;
            period_code_q <= 2'd3;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            led_q         <= led_d;
            beat_pulse_q  <= beat_pulse_d;
            beat_count_q  <= beat_count_d;
            period_code_q <= period_code_d;
        end
    end

    assign led         = led_q;
    assign beat_pulse  = beat_pulse_q;
    assign beat_count  = beat_count_q;
    assign period_code = period_code_q;

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_heartbeat_pulse_gen
//  Description : Self-checking bench for heartbeat_pulse_gen. Stimulus pushes
//                expected beats (count, code, spacing) into a queue; a monitor
//                pops one entry for every beat_pulse the DUT produces.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_heartbeat_pulse_gen;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       tick;
    logic [1:0] heartbeat;
    logic       led;
    logic       beat_pulse;
    logic [7:0] beat_count;
    logic [1:0] period_code;

    typedef struct {
        logic [7:0] cnt;
        logic [1:0] code;
        int         spacing;   // clk cycles since previous beat; 0 = don't care
    } beat_t;

    beat_t exp_q[$];
    int    checks    = 0;
    int    failures  = 0;
    int    cyc       = 0;
    int    last_cyc  = 0;
    logic [1:0] last_code;

    heartbeat_pulse_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .tick        (tick),
        .heartbeat   (heartbeat),
        .led         (led),
        .beat_pulse  (beat_pulse),
        .beat_count  (beat_count),
        .period_code (period_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Lub-dub waveform with ON=2, GAP=2: lit on tick offsets 0,1 and 4,5.
    function automatic int led_exp(input int x);
        return ((x < 2) || (x >= 4 && x < 6)) ? 1 : 0;
    endfunction

    // Monitor: every DUT beat must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && beat_pulse) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_count", int'(beat_count), int'(e.cnt));
                chk("period_code", int'(period_code), int'(e.code));
                chk("led_at_beat", int'(led), 1);
                if (e.spacing != 0) chk("beat_spacing", cyc - last_cyc, e.spacing);
            end
            last_cyc = cyc;
        end
    end

    task automatic push_beat(input int k, input logic [1:0] code, input int spacing);
        beat_t e;
        e.cnt     = 8'(k);
        e.code    = code;
        e.spacing = spacing;
        exp_q.push_back(e);
    endtask

    // Drop enable for one edge (checking the IDLE state), then run n beats
    // with tick every cycle. Returns just after the edge of the last beat.
    task automatic run_beats(input logic [1:0] code, input int period,
                             input int n, input bit do_led);
        enable = 1'b0;
        tick   = 1'b0;
        @(posedge clk); #1;
        chk("idle_led", int'(led), 0);
        chk("idle_count", int'(beat_count), 0);
        chk("idle_pulse", int'(beat_pulse), 0);
        chk("idle_code_hold", int'(period_code), int'(last_code));
        heartbeat = code;
        enable    = 1'b1;
        tick      = 1'b1;
        for (int k = 1; k <= n; k++) push_beat(k, code, (k == 1) ? 0 : period);
        for (int i = 0; i < (n - 1) * period + 1; i++) begin
            @(posedge clk); #1;
            if (do_led) chk("led_wave", int'(led), led_exp(i % period));
        end
        last_code = code;
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        tick      = 1'b0;
        heartbeat = 2'd0;
        last_code = 2'd3;

        // Reset held: outputs stay at reset values whatever the inputs do.
        for (int i = 0; i < 6; i++) begin
            enable    = i[0];
            tick      = 1'b1;
            heartbeat = 2'(i);
            @(posedge clk); #1;
            chk("rst_led", int'(led), 0);
            chk("rst_pulse", int'(beat_pulse), 0);
            chk("rst_count", int'(beat_count), 0);
            chk("rst_code", int'(period_code), 3);
        end
        enable = 1'b0;
        rst_n  = 1'b1;

        // Normal rate, then each other code.
        run_beats(2'd1, 16, 3, 1'b1);
        chk("count_after_3", int'(beat_count), 3);
        chk("code_normal", int'(period_code), 1);
        run_beats(2'd0, 10, 3, 1'b1);
        run_beats(2'd2, 24, 3, 1'b1);
        run_beats(2'd3, 40, 3, 1'b1);

        // Mid-beat change: code 3 -> 0 during GAP of the first beat.
        enable = 1'b0; tick = 1'b0;
        @(posedge clk); #1;
        heartbeat = 2'd3; enable = 1'b1; tick = 1'b1;
        push_beat(1, 2'd3, 0);
        push_beat(2, 2'd0, 40);
        push_beat(3, 2'd0, 10);
        repeat (3) @(posedge clk);
        #1;
        chk("gap_led", int'(led), 0);
        heartbeat = 2'd0;
        repeat (48) @(posedge clk);
        #1;
        last_code = 2'd0;

        // Sparse tick: one tick every 4 clk, code 1 -> 64 clk per beat.
        enable = 1'b0; tick = 1'b0;
        @(posedge clk); #1;
        heartbeat = 2'd1; enable = 1'b1;
        push_beat(1, 2'd1, 0);
        push_beat(2, 2'd1, 64);
        push_beat(3, 2'd1, 64);
        for (int i = 0; i <= 128; i++) begin
            tick = (i % 4 == 0);
            @(posedge clk); #1;
            chk("sparse_led", int'(led), led_exp((i / 4) % 16));
        end
        tick = 1'b0;
        last_code = 2'd1;

        // Drop enable during DUB, then re-enable.
        enable = 1'b0;
        @(posedge clk); #1;
        heartbeat = 2'd1; enable = 1'b1; tick = 1'b1;
        push_beat(1, 2'd1, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("dub_led", int'(led), 1);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("drop_led", int'(led), 0);
        chk("drop_count", int'(beat_count), 0);
        chk("drop_pulse", int'(beat_pulse), 0);
        run_beats(2'd1, 16, 1, 1'b1);
        chk("reenable_count", int'(beat_count), 1);

        // Asynchronous reset mid-REST, applied between clock edges.
        enable = 1'b0; tick = 1'b0;
        @(posedge clk); #1;
        heartbeat = 2'd1; enable = 1'b1; tick = 1'b1;
        push_beat(1, 2'd1, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("rest_count", int'(beat_count), 1);
        chk("rest_led", int'(led), 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_led", int'(led), 0);
        chk("async_pulse", int'(beat_pulse), 0);
        chk("async_count", int'(beat_count), 0);
        chk("async_code", int'(period_code), 3);
        enable = 1'b0; tick = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_code = 2'd3;

        // 256 beats at the fast rate: count wraps 255 -> 0.
        run_beats(2'd0, 10, 256, 1'b0);
        chk("wrap_count", int'(beat_count), 0);
        chk("wrap_code", int'(period_code), 0);

        enable = 1'b0; tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pending_beats", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the directed run is far shorter than this bound.
    initial begin
        #500000;
        failures = failures + 1;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
